// File: rtl/axi4_slave_interface_pkg.sv
// Shared definitions for the AXI4 slave interface: burst/response codes,
// state encodings and the burst support check used by both channels.
package axi4_slave_interface_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_CMD,
    W_FWD,
    W_DRAIN,
    W_RESP
  } writeState_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CMD,
    R_FWD,
    R_ERR
  } readState_t;

  // Only full-width INCR bursts map onto the inner command interface.
  function automatic logic isSupported(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [2:0] fullSize);
    return (burst == BURST_INCR) && (size == fullSize);
  endfunction

endpackage

// File: rtl/axi4_slave_interface_if.sv
// AXI4 slave-side bus bundle (AW/W/B/AR/R); the slave modport faces the
// responder, the master modport faces the interconnect or a bench.
interface axi4_slave_interface_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);

  logic [AddressWidth-1:0] S_AWADDR;
  logic [7:0]              S_AWLEN;
  logic [2:0]              S_AWSIZE;
  logic [1:0]              S_AWBURST;
  logic                    S_AWVALID;
  logic                    S_AWREADY;

  logic [DataWidth-1:0]    S_WDATA;
  logic [DataWidth/8-1:0]  S_WSTRB;
  logic                    S_WLAST;
  logic                    S_WVALID;
  logic                    S_WREADY;

  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;

  logic [AddressWidth-1:0] S_ARADDR;
  logic [7:0]              S_ARLEN;
  logic [2:0]              S_ARSIZE;
  logic [1:0]              S_ARBURST;
  logic                    S_ARVALID;
  logic                    S_ARREADY;

  logic [DataWidth-1:0]    S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RLAST;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_WREADY,
    output S_BRESP, S_BVALID,
    input  S_BREADY,
    input  S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
    output S_ARREADY,
    output S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  S_RREADY
  );

  modport master (
    output S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_WREADY,
    input  S_BRESP, S_BVALID,
    output S_BREADY,
    output S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
    input  S_ARREADY,
    input  S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output S_RREADY
  );

endinterface

// File: rtl/axi4_slave_interface_beat_counter.sv
// Burst beat down-counter: loads AXI LEN on address acceptance, counts data
// handshakes down and flags the final beat when it reaches zero.
module axi4_beat_counter (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       load,
  input  logic [7:0] len,
  input  logic       beat,
  output logic       last
);

  logic [7:0] count;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (beat && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign last = (count == 8'd0);

endmodule

// File: rtl/axi4_slave_interface.sv
// AXI4 slave that turns each single-outstanding INCR burst into one inner
// command (address, beats, req/ack) plus a pass-through data stream.
module axi4_slave_interface
  import axi4_slave_interface_pkg::*;
#(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int InnerIFLengthWidth = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  axi4_slave_interface_if.slave         axi,
  output logic [AddressWidth-1:0]       oWriteAddress,
  output logic [InnerIFLengthWidth-1:0] oWriteBeats,
  output logic                          oWriteCommandReq,
  input  logic                          iWriteCommandAck,
  output logic [DataWidth-1:0]          oWriteData,
  output logic                          oWriteLast,
  output logic                          oWriteValid,
  input  logic                          iWriteReady,
  output logic [AddressWidth-1:0]       oReadAddress,
  output logic [InnerIFLengthWidth-1:0] oReadBeats,
  output logic                          oReadCommandReq,
  input  logic                          iReadCommandAck,
  input  logic [DataWidth-1:0]          iReadData,
  input  logic                          iReadValid,
  output logic                          oReadReady
);

  localparam logic [2:0] FullSize = 3'($clog2(DataWidth / 8));

  writeState_t writeState, writeNext;
  readState_t  readState, readNext;
  logic        writeErr;
  logic        awReady, wReady, bValid, wLoad, wBeat, wCntLast;
  logic        arReady, rValid, rLast, rLoad, rBeat, rCntLast;
  logic [DataWidth-1:0] rData;
  logic [1:0]  rResp;
  logic        unusedSignals;

  assign unusedSignals = ^axi.S_WSTRB;

  axi4_beat_counter writeCounter (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load    (wLoad),
    .len     (axi.S_AWLEN),
    .beat    (wBeat),
    .last    (wCntLast)
  );

  axi4_beat_counter readCounter (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load    (rLoad),
    .len     (axi.S_ARLEN),
    .beat    (rBeat),
    .last    (rCntLast)
  );

  // Write path: unsupported bursts are drained and answered with SLVERR
  // without ever reaching the inner command interface.
  always_comb begin
    writeNext        = writeState;
    awReady          = 1'b0;
    wReady           = 1'b0;
    bValid           = 1'b0;
    oWriteCommandReq = 1'b0;
    oWriteValid      = 1'b0;
    oWriteLast       = 1'b0;
    wLoad            = 1'b0;
    wBeat            = 1'b0;
    case (writeState)
      W_IDLE: begin
        awReady = 1'b1;
        if (axi.S_AWVALID) begin
          wLoad     = 1'b1;
          writeNext = isSupported(axi.S_AWBURST, axi.S_AWSIZE, FullSize) ? W_CMD : W_DRAIN;
        end
      end
      W_CMD: begin
        oWriteCommandReq = 1'b1;
        if (iWriteCommandAck) writeNext = W_FWD;
      end
      W_FWD: begin
        wReady      = iWriteReady;
        oWriteValid = axi.S_WVALID;
        oWriteLast  = wCntLast;
        wBeat       = axi.S_WVALID && iWriteReady;
        if (wBeat && wCntLast) writeNext = W_RESP;
      end
      W_DRAIN: begin
        wReady = 1'b1;
        wBeat  = axi.S_WVALID;
        if (wBeat && wCntLast) writeNext = W_RESP;
      end
      W_RESP: begin
        bValid = 1'b1;
        if (axi.S_BREADY) writeNext = W_IDLE;
      end
      default: writeNext = W_IDLE;
    endcase
  end

  // The captured command stays stable until the burst's response completes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      writeState    <= W_IDLE;
      writeErr      <= 1'b0;
      oWriteAddress <= '0;
      oWriteBeats   <= '0;
    end else begin
      writeState <= writeNext;
      if (wLoad) begin
        oWriteAddress <= axi.S_AWADDR;
        oWriteBeats   <= InnerIFLengthWidth'(axi.S_AWLEN) + InnerIFLengthWidth'(1);
        writeErr      <= !isSupported(axi.S_AWBURST, axi.S_AWSIZE, FullSize);
      end else if ((writeState == W_FWD) && wBeat && (axi.S_WLAST != wCntLast)) begin
        writeErr <= 1'b1;
      end else if (bValid && axi.S_BREADY) begin
        writeErr <= 1'b0;
      end
    end
  end

  assign axi.S_AWREADY = awReady;
  assign axi.S_WREADY  = wReady;
  assign axi.S_BVALID  = bValid;
  assign axi.S_BRESP   = writeErr ? RESP_SLVERR : RESP_OKAY;
  assign oWriteData    = axi.S_WDATA;

  // Read path: unsupported bursts are answered locally with zero SLVERR beats.
  always_comb begin
    readNext        = readState;
    arReady         = 1'b0;
    rValid          = 1'b0;
    rLast           = 1'b0;
    rData           = '0;
    rResp           = RESP_OKAY;
    oReadCommandReq = 1'b0;
    oReadReady      = 1'b0;
    rLoad           = 1'b0;
    rBeat           = 1'b0;
    case (readState)
      R_IDLE: begin
        arReady = 1'b1;
        if (axi.S_ARVALID) begin
          rLoad    = 1'b1;
          readNext = isSupported(axi.S_ARBURST, axi.S_ARSIZE, FullSize) ? R_CMD : R_ERR;
        end
      end
      R_CMD: begin
        oReadCommandReq = 1'b1;
        if (iReadCommandAck) readNext = R_FWD;
      end
      R_FWD: begin
        rValid     = iReadValid;
        oReadReady = axi.S_RREADY;
        rData      = iReadData;
        rLast      = rCntLast;
        rBeat      = iReadValid && axi.S_RREADY;
        if (rBeat && rCntLast) readNext = R_IDLE;
      end
      R_ERR: begin
        rValid = 1'b1;
        rResp  = RESP_SLVERR;
        rLast  = rCntLast;
        rBeat  = axi.S_RREADY;
        if (rBeat && rCntLast) readNext = R_IDLE;
      end
      default: readNext = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      readState    <= R_IDLE;
      oReadAddress <= '0;
      oReadBeats   <= '0;
    end else begin
      readState <= readNext;
      if (rLoad) begin
        oReadAddress <= axi.S_ARADDR;
        oReadBeats   <= InnerIFLengthWidth'(axi.S_ARLEN) + InnerIFLengthWidth'(1);
      end
    end
  end

  assign axi.S_ARREADY = arReady;
  assign axi.S_RVALID  = rValid;
  assign axi.S_RLAST   = rLast;
  assign axi.S_RDATA   = rData;
  assign axi.S_RRESP   = rResp;

endmodule
